rgb2hsv_pipe: RTL and testbench

- Streaming RGB888 to HSV888 converter that consumes the HDMI-style pixel stream (DE, HSYNC, VSYNC, R, G, B) produced by the video source stage.
- Fully pipelined: accepts one pixel per clock and has a fixed latency of 4 clocks.
- Sync and DE are delayed by the same 4 clocks, so the output stream stays timing-aligned for the downstream threshold/mask stages.
- Division is done with reciprocal ROM lookups and multipliers; there is no iterative divider.

---
 rtl/rgb2hsv_pipe.sv | 231 +++++++++++++++++++++++
 tb/tb_rgb2hsv_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb2hsv_pipe.sv
// rgb2hsv_pipe: streaming RGB888 -> HSV888 converter with a fixed 4-clock latency.
// DE/HSYNC/VSYNC travel through matching delay lines so the output stream stays aligned.
// Division uses reciprocal ROMs (ceil(65536/d)) and multipliers.
// Optional build macro: RGB2HSV_DE_MASK_EN forces out_h/out_s/out_v to 0 whenever out_de is 0.
module rgb2hsv_pipe #(
    parameter int LATENCY = 4,
    parameter int RECIP_W = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_de,
    input  logic       in_hsync,
    input  logic       in_vsync,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    output logic       out_de,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic [7:0] out_h,
    output logic [7:0] out_s,
    output logic [7:0] out_v
);

    // Product width: 15-bit signed hue term times zero-extended reciprocal.
    localparam int PW = 16 + RECIP_W;

    // ------------------------------------------------------------------
    // Reciprocal ROM: entry d holds ceil(65536/d); entry 0 is never used.
    // ------------------------------------------------------------------
    logic [RECIP_W-1:0] recip_rom [256];

    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_recip
            if (gi == 0) begin : g_zero
                assign recip_rom[gi] = '0;
            end else begin : g_val
                assign recip_rom[gi] = RECIP_W'((65536 + gi - 1) / gi);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: max/min and hue sector decode (tie priority R > G > B)
    // ------------------------------------------------------------------
    logic [7:0]        max1_d, max1_q;
    logic [7:0]        min1_d, min1_q;
    logic [7:0]        base1_d, base1_q;
    logic signed [8:0] diff1_d, diff1_q;

    // Pick the dominant channel and the matching hue offset/difference.
    always_comb begin
        max1_d  = in_r;
        base1_d = 8'd0;
        diff1_d = {1'b0, in_g} - {1'b0, in_b};
        if (in_r >= in_g && in_r >= in_b) begin
            max1_d  = in_r;
            base1_d = 8'd0;
            diff1_d = {1'b0, in_g} - {1'b0, in_b};
        end else if (in_g >= in_b) begin
            max1_d  = in_g;
            base1_d = 8'd85;
            diff1_d = {1'b0, in_b} - {1'b0, in_r};
        end else begin
            max1_d  = in_b;
            base1_d = 8'd171;
            diff1_d = {1'b0, in_r} - {1'b0, in_g};
        end
        min1_d = in_r;
        if (in_g < min1_d) min1_d = in_g;
        if (in_b < min1_d) min1_d = in_b;
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            max1_q  <= '0;
            min1_q  <= '0;
            base1_q <= '0;
            diff1_q <= '0;
        end else begin
            max1_q  <= max1_d;
            min1_q  <= min1_d;
            base1_q <= base1_d;
            diff1_q <= diff1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: chroma range, reciprocal lookups, hue numerator scaling
    // ------------------------------------------------------------------
    logic [7:0]         delta2_d, delta2_q;
    logic [RECIP_W-1:0] rd2_d, rd2_q;
    logic [RECIP_W-1:0] rm2_d, rm2_q;
    logic signed [14:0] hh2_d, hh2_q;
    logic [7:0]         max2_q;
    logic [7:0]         base2_q;

    // Reciprocals of delta and max; 43 = 256/6 scales one hue sector.
    always_comb begin
        delta2_d = max1_q - min1_q;
        rd2_d    = recip_rom[delta2_d];
        rm2_d    = recip_rom[max1_q];
        hh2_d    = $signed({{6{diff1_q[8]}}, diff1_q}) * 15'sd43;
    end

    // Stage 2 register (ROM reads are registered here).
    always_ff @(posedge clk) begin
        if (rst) begin
            delta2_q <= '0;
            rd2_q    <= '0;
            rm2_q    <= '0;
            hh2_q    <= '0;
            max2_q   <= '0;
            base2_q  <= '0;
        end else begin
            delta2_q <= delta2_d;
            rd2_q    <= rd2_d;
            rm2_q    <= rm2_d;
            hh2_q    <= hh2_d;
            max2_q   <= max1_q;
            base2_q  <= base1_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: full-width products (no truncation before the shift)
    // ------------------------------------------------------------------
    logic signed [PW-1:0] ph3_d, ph3_q;
    logic [PW-1:0]        ps3_d, ps3_q;
    logic                 dz3_d, dz3_q;
    logic [7:0]           max3_q;
    logic [7:0]           base3_q;

    // Hue product is signed; saturation product is unsigned 255*delta*RECIP[max].
    always_comb begin
        ph3_d = $signed({{(PW-15){hh2_q[14]}}, hh2_q}) *
                $signed({{(PW-RECIP_W){1'b0}}, rd2_q});
        ps3_d = {{(PW-8){1'b0}}, delta2_q} *
                {{(PW-RECIP_W){1'b0}}, rm2_q} *
                {{(PW-8){1'b0}}, 8'd255};
        dz3_d = (delta2_q == 8'd0);
    end

    // Stage 3 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph3_q   <= '0;
            ps3_q   <= '0;
            dz3_q   <= 1'b0;
            max3_q  <= '0;
            base3_q <= '0;
        end else begin
            ph3_q   <= ph3_d;
            ps3_q   <= ps3_d;
            dz3_q   <= dz3_d;
            max3_q  <= max2_q;
            base3_q <= base2_q;
        end
    end

    // ------------------------------------------------------------------
    // Control delay lines (DE resets low, syncs reset to idle-high)
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] de_q;
    logic [LATENCY-1:0] hs_q;
    logic [LATENCY-1:0] vs_q;

    // Shift DE and syncs by the pipeline depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q <= '0;
            hs_q <= '1;
            vs_q <= '1;
        end else begin
            de_q <= {de_q[LATENCY-2:0], in_de};
            hs_q <= {hs_q[LATENCY-2:0], in_hsync};
            vs_q <= {vs_q[LATENCY-2:0], in_vsync};
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: final H/S/V
    // ------------------------------------------------------------------
    logic [7:0] h4_d, h4_q;
    logic [7:0] s4_d, s4_q;
    logic [7:0] v4_d, v4_q;

    // ph[23:16] is (ph >>> 16) mod 256, so adding it to base gives the wrapped hue.
    always_comb begin
        v4_d = max3_q;
        h4_d = 8'd0;
        s4_d = 8'd0;
        if (!dz3_q) begin
            h4_d = base3_q + ph3_q[23:16];
            s4_d = (|ps3_q[PW-1:24]) ? 8'd255 : ps3_q[23:16];
        end
`ifdef RGB2HSV_DE_MASK_EN
        if (!de_q[LATENCY-2]) begin
            h4_d = 8'd0;
            s4_d = 8'd0;
            v4_d = 8'd0;
        end
`endif
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            h4_q <= '0;
            s4_q <= '0;
            v4_q <= '0;
        end else begin
            h4_q <= h4_d;
            s4_q <= s4_d;
            v4_q <= v4_d;
        end
    end

    // Fractional and headroom bits of the products are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{ph3_q[PW-1:24], ph3_q[15:0], ps3_q[15:0]};

    assign out_de    = de_q[LATENCY-1];
    assign out_hsync = hs_q[LATENCY-1];
    assign out_vsync = vs_q[LATENCY-1];
    assign out_h     = h4_q;
    assign out_s     = s4_q;
    assign out_v     = v4_q;

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// tb_rgb2hsv_pipe: scoreboard bench for rgb2hsv_pipe. Stimulus pushes expected
// outputs (tagged with the cycle they are due) and a negedge monitor compares.
module tb_rgb2hsv_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_de, in_hsync, in_vsync;
    logic [7:0] in_r, in_g, in_b;
    logic       out_de, out_hsync, out_vsync;
    logic [7:0] out_h, out_s, out_v;

    rgb2hsv_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_de     (in_de),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .out_de    (out_de),
        .out_hsync (out_hsync),
        .out_vsync (out_vsync),
        .out_h     (out_h),
        .out_s     (out_s),
        .out_v     (out_v)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        bit         de, hs, vs;
        logic [7:0] h, s, v;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference: HSV from the arithmetic definition, whole-pixel at once.
    function automatic void hsv_ref(input int r, input int g, input int b, input bit de,
                                    output logic [7:0] h, output logic [7:0] s,
                                    output logic [7:0] v);
        int mx, mn, base, diff, delta, hue;
        longint rd, rm, ph, ps, sh;
        if (r >= g && r >= b)  begin mx = r; base = 0;   diff = g - b; end
        else if (g >= b)       begin mx = g; base = 85;  diff = b - r; end
        else                   begin mx = b; base = 171; diff = r - g; end
        mn = r;
        if (g < mn) mn = g;
        if (b < mn) mn = b;
        delta = mx - mn;
        v = 8'(mx);
        if (delta == 0) begin
            h = 0;
            s = 0;
        end else begin
            rd  = (65536 + delta - 1) / delta;
            rm  = (65536 + mx - 1) / mx;
            ph  = longint'(43 * diff) * rd;
            sh  = ph >>> 16;
            hue = base + int'(sh);
            h   = 8'(hue & 255);
            ps  = longint'(255 * delta) * rm;
            ps  = ps >> 16;
            s   = (ps > 255) ? 8'd255 : 8'(ps);
        end
`ifdef RGB2HSV_DE_MASK_EN
        if (!de) begin
            h = 0;
            s = 0;
            v = 0;
        end
`endif
    endfunction

    // Apply one clock of stimulus and record what must come out 4 clocks later.
    task automatic drive(input bit r_st, input bit de, input bit hs, input bit vs,
                         input int r, input int g, input int b,
                         input bit fixed, input int eh, input int es, input int ev);
        exp_t e;
        rst      = r_st;
        in_de    = de;
        in_hsync = hs;
        in_vsync = vs;
        in_r     = 8'(r);
        in_g     = 8'(g);
        in_b     = 8'(b);
        if (r_st) begin
            // Reset flushes everything in flight; those slots show reset values.
            while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
            for (int k = 1; k <= 4; k++) begin
                e.due = cyc + k; e.de = 0; e.hs = 1; e.vs = 1;
                e.h = 0; e.s = 0; e.v = 0;
                q.push_back(e);
            end
        end else begin
            e.due = cyc + 4; e.de = de; e.hs = hs; e.vs = vs;
            if (fixed) begin
                e.h = 8'(eh); e.s = 8'(es); e.v = 8'(ev);
            end else begin
                hsv_ref(r, g, b, de, e.h, e.s, e.v);
            end
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic blank(input bit hs, input bit vs);
        drive(0, 0, hs, vs, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input int r, input int g, input int b);
        drive(0, 1, 1, 1, r, g, b, 0, 0, 0, 0);
    endtask

    function automatic int pick();
        int sel;
        sel = int'($urandom_range(0, 5));
        if (sel == 0) return 0;
        if (sel == 1) return 255;
        if (sel == 2) return 128;
        return int'($urandom_range(0, 255));
    endfunction

    // Monitor: one comparison per output cycle that has an expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            n_checks++;
            $display("FAIL missed_slot due=%0d now=%0d", e.due, cyc);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            n_checks++;
            if (out_de === e.de && out_hsync === e.hs && out_vsync === e.vs &&
                out_h === e.h && out_s === e.s && out_v === e.v) begin
                n_pass++;
                $display("cyc=%0d de=%b hs=%b vs=%b hsv=%0d,%0d,%0d ok",
                         cyc, out_de, out_hsync, out_vsync, out_h, out_s, out_v);
            end else begin
                $display("FAIL out_slot cyc=%0d got de/hs/vs=%b%b%b hsv=%0d,%0d,%0d want de/hs/vs=%b%b%b hsv=%0d,%0d,%0d",
                         cyc, out_de, out_hsync, out_vsync, out_h, out_s, out_v,
                         e.de, e.hs, e.vs, e.h, e.s, e.v);
            end
        end
    end

    // Directed pixels; eh < 0 means use the reference model.
    int dr[8] = '{255,   0,   0, 100, 0, 255, 255, 200};
    int dg[8] = '{  0, 255,   0, 100, 0,   0, 128, 100};
    int db[8] = '{  0,   0, 255, 100, 0, 255,   0,  50};
    int dh[8] = '{  0,  85, 171,   0, 0, 212,  21,  -1};
    int ds[8] = '{255, 255, 255,   0, 0, 255, 255,  -1};
    int dv[8] = '{255, 255, 255, 100, 0, 255, 255,  -1};

    initial begin
        // Power-on reset.
        for (int k = 0; k < 4; k++) drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        while (cyc < 10) blank(1, 1);
        // Single-cycle DE pulse at cycle 10 carrying pure red.
        drive(0, 1, 1, 1, 255, 0, 0, 1, 0, 255, 255);
        while (cyc < 20) blank(1, 1);
        // HSYNC low at cycles 20-21.
        blank(0, 1);
        blank(0, 1);
        blank(1, 1);
        blank(1, 0);
        // Directed table.
        for (int k = 0; k < 8; k++) begin
            if (dh[k] < 0) pix(dr[k], dg[k], db[k]);
            else drive(0, 1, 1, 1, dr[k], dg[k], db[k], 1, dh[k], ds[k], dv[k]);
        end
        // Back-to-back active stream of 64 pixels.
        for (int k = 0; k < 64; k++) pix(pick(), pick(), pick());
        // Mixed random DE/sync/data.
        for (int k = 0; k < 100; k++)
            drive(0, 1'($urandom), 1'($urandom), 1'($urandom),
                  pick(), pick(), pick(), 0, 0, 0, 0);
        // Reset for one cycle during active video.
        for (int k = 0; k < 5; k++) pix(pick(), pick(), pick());
        drive(1, 1, 1, 1, 255, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) pix(pick(), pick(), pick());
        // Blanking carrying pure red: masked build shows zeros, default shows the conversion.
        for (int k = 0; k < 4; k++) begin
`ifdef RGB2HSV_DE_MASK_EN
            drive(0, 0, 1, 1, 255, 0, 0, 1, 0, 0, 0);
`else
            drive(0, 0, 1, 1, 255, 0, 0, 1, 0, 255, 255);
`endif
        end
        for (int k = 0; k < 6; k++) blank(1, 1);
        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
